// File: rtl/matmul_pkg.sv
// rtl/matmul_pkg.sv - shared types and constants for the 2x2 signed matrix multiplier datapath
package matmul_pkg;

  localparam int W_ELEM = 4;
  localparam int NELEM  = 8;
  localparam int N_DIM  = 2;

  typedef logic signed [W_ELEM-1:0] elem_t;

  typedef enum logic {
    LOAD    = 1'b0,
    PRESENT = 1'b1
  } loader_state_t;

endpackage

// File: rtl/mat2x2_operand_loader.sv
// rtl/mat2x2_operand_loader.sv - serial-to-parallel operand loader for the 2x2 multiplier
// Optional framing check on s_last is enabled by defining MATLOAD_FRAME_CHECK_EN.
module mat2x2_operand_loader
  import matmul_pkg::*;
#(
  parameter int W = W_ELEM
) (
  input  logic                clk,
  input  logic                rst,
  input  logic signed [W-1:0] s_data,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic                s_last,
  output logic signed [W-1:0] a0,
  output logic signed [W-1:0] a1,
  output logic signed [W-1:0] a2,
  output logic signed [W-1:0] a3,
  output logic signed [W-1:0] b0,
  output logic signed [W-1:0] b1,
  output logic signed [W-1:0] b2,
  output logic signed [W-1:0] b3,
  output logic                op_valid,
  input  logic                op_ready,
  output logic                err
);

  localparam int                IDX_W    = $clog2(NELEM);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NELEM - 1);

  loader_state_t       state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic signed [W-1:0] ops_q [NELEM];
  logic signed [W-1:0] ops_d [NELEM];
  logic                accept;
  logic                frame_abort;
  logic                frame_err;

  assign s_ready  = (state_q == LOAD) && !rst;
  assign op_valid = (state_q == PRESENT);
  assign accept   = s_valid && s_ready;

`ifdef MATLOAD_FRAME_CHECK_EN
  logic err_q, err_d;

  // An early s_last throws the partial set away; a missing s_last is only flagged.
  assign frame_abort = s_last && (idx_q != LAST_IDX);
  assign frame_err   = s_last != (idx_q == LAST_IDX);

  always_comb begin
    err_d = err_q;
    if (accept && frame_err) err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign err = err_q;
`else
  logic unused_s_last;

  assign unused_s_last = s_last;
  assign frame_abort   = 1'b0;
  assign frame_err     = 1'b0;
  assign err           = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ops_d   = ops_q;
    case (state_q)
      LOAD: begin
        if (accept) begin
          if (frame_abort) begin
            idx_d = '0;
          end else begin
            ops_d[idx_q] = s_data;
            idx_d        = idx_q + 1'b1;
            if (idx_q == LAST_IDX) state_d = PRESENT;
          end
        end
      end
      PRESENT: begin
        if (op_ready) state_d = LOAD;
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LOAD;
      idx_q   <= '0;
      for (int i = 0; i < NELEM; i++) ops_q[i] <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ops_q   <= ops_d;
    end
  end

  assign a0 = ops_q[0];
  assign a1 = ops_q[1];
  assign a2 = ops_q[2];
  assign a3 = ops_q[3];
  assign b0 = ops_q[4];
  assign b1 = ops_q[5];
  assign b2 = ops_q[6];
  assign b3 = ops_q[7];

endmodule

// File: tb/tb_mat2x2_operand_loader.sv
// tb/tb_mat2x2_operand_loader.sv - randomized self-checking bench for mat2x2_operand_loader
module tb_mat2x2_operand_loader;

  logic              clk = 1'b0;
  logic              rst;
  logic signed [3:0] s_data;
  logic              s_valid;
  logic              s_ready;
  logic              s_last;
  logic signed [3:0] a0, a1, a2, a3, b0, b1, b2, b3;
  logic              op_valid;
  logic              op_ready;
  logic              err;

  int n_vec  = 0;
  int n_miss = 0;

  logic [3:0] m_ops [8];
  bit         m_present;
  int         m_cnt;
  bit         m_err;
  int         ov_high;

  mat2x2_operand_loader #(.W(4)) dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .s_last(s_last), .a0(a0), .a1(a1), .a2(a2), .a3(a3), .b0(b0), .b1(b1),
    .b2(b2), .b3(b3), .op_valid(op_valid), .op_ready(op_ready), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: a set is a list of 8 elements filled in order; presentation is a single flag.
  task automatic model_step();
    if (rst) begin
      for (int i = 0; i < 8; i++) m_ops[i] = '0;
      m_present = 0;
      m_cnt     = 0;
      m_err     = 0;
    end else if (!m_present && s_valid) begin
`ifdef MATLOAD_FRAME_CHECK_EN
      if (s_last && m_cnt < 7) begin
        m_err = 1;
        m_cnt = 0;
      end else begin
        if (m_cnt == 7 && !s_last) m_err = 1;
`endif
        m_ops[m_cnt] = s_data;
        if (m_cnt == 7) begin
          m_present = 1;
          m_cnt     = 0;
        end else begin
          m_cnt++;
        end
`ifdef MATLOAD_FRAME_CHECK_EN
      end
`endif
    end else if (m_present && op_ready) begin
      m_present = 0;
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    @(negedge clk);
    if (op_valid) ov_high++;
    chk("op_valid", {7'd0, op_valid}, {7'd0, m_present});
    chk("s_ready", {7'd0, s_ready}, {7'd0, !m_present && !rst});
    chk("err", {7'd0, err}, {7'd0, m_err});
    chk("a0", {4'd0, a0}, {4'd0, m_ops[0]});
    chk("a1", {4'd0, a1}, {4'd0, m_ops[1]});
    chk("a2", {4'd0, a2}, {4'd0, m_ops[2]});
    chk("a3", {4'd0, a3}, {4'd0, m_ops[3]});
    chk("b0", {4'd0, b0}, {4'd0, m_ops[4]});
    chk("b1", {4'd0, b1}, {4'd0, m_ops[5]});
    chk("b2", {4'd0, b2}, {4'd0, m_ops[6]});
    chk("b3", {4'd0, b3}, {4'd0, m_ops[7]});
  endtask

  task automatic send(input logic [3:0] d, input bit last, input int gap_pct);
    bit done = 0;
    for (int t = 0; t < 64 && !done; t++) begin
      s_valid = ($urandom_range(99) >= gap_pct);
      s_data  = s_valid ? d : 4'($urandom);
      s_last  = last;
      done    = s_valid && !m_present && !rst;
      cycle();
    end
    s_valid = 0;
    if (!done) chk("send_timeout", 8'd0, 8'd1);
  endtask

  task automatic send_set(input logic [3:0] d [8], input int gap_pct);
    for (int i = 0; i < 8; i++) send(d[i], i == 7, gap_pct);
  endtask

  task automatic do_reset();
    rst = 1;
    cycle();
    cycle();
    rst = 0;
  endtask

  logic [3:0] set [8];

  initial begin
    rst = 1; s_data = '0; s_valid = 0; s_last = 0; op_ready = 0; ov_high = 0;
    cycle();
    cycle();
    rst = 0;
    cycle();

    // Straight 1..8 with s_valid held high.
    for (int i = 0; i < 8; i++) set[i] = 4'(i + 1);
    send_set(set, 0);
    chk("t1_a0", {4'd0, a0}, 8'h01);
    chk("t1_b3", {4'd0, b3}, 8'h08);
    chk("t1_op_valid", {7'd0, op_valid}, 8'h01);

    // Frozen in PRESENT despite s_valid, then release.
    s_valid = 1; s_data = 4'd9; s_last = 0;
    for (int i = 0; i < 10; i++) cycle();
    chk("t2_a2", {4'd0, a2}, 8'h03);
    s_valid = 0;
    op_ready = 1;
    cycle();
    op_ready = 0;
    chk("t2_released", {7'd0, s_ready}, 8'h01);

    // Signed values with random gaps.
    set = '{4'h8, 4'h7, 4'hF, 4'h0, 4'h3, 4'hC, 4'hE, 4'h5};
    send_set(set, 40);
    chk("t3_a0", {4'd0, a0}, 8'h08);
    chk("t3_b1", {4'd0, b1}, 8'h0C);
    op_ready = 1;
    cycle();
    op_ready = 0;

    // Reset after 5 accepts discards the partial set.
    for (int i = 0; i < 5; i++) send(4'($urandom), 0, 20);
    do_reset();
    chk("t4_a0_rst", {4'd0, a0}, 8'h00);
    for (int i = 0; i < 8; i++) set[i] = 4'($urandom);
    send_set(set, 20);

    // Back-to-back sets with op_ready tied high: op_valid high one cycle per set.
    op_ready = 1;
    ov_high  = 0;
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 8; i++) set[i] = 4'($urandom);
      send_set(set, 0);
    end
    cycle();
    chk("t5_ov_cycles", 8'(ov_high), 8'd3);
    op_ready = 0;

`ifdef MATLOAD_FRAME_CHECK_EN
    do_reset();
    send(4'd1, 0, 0);
    send(4'd2, 0, 0);
    send(4'd3, 1, 0);
    chk("t6_err", {7'd0, err}, 8'h01);
    for (int i = 0; i < 8; i++) set[i] = 4'(i + 4);
    send_set(set, 10);
    chk("t6_a0", {4'd0, a0}, 8'h04);
    chk("t6_err_hold", {7'd0, err}, 8'h01);
    op_ready = 1;
    cycle();
    op_ready = 0;
    do_reset();
    chk("t6_err_clr", {7'd0, err}, 8'h00);
`endif

    // Random soak.
    for (int c = 0; c < 400; c++) begin
      rst      = ($urandom_range(99) < 2);
      s_valid  = ($urandom_range(99) < 70);
      op_ready = ($urandom_range(99) < 30);
      s_data   = 4'($urandom);
      s_last   = ($urandom_range(99) < 12);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
